// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART RX control slice: the config FSM state
// encoding, the prescale value restored on reset, default parameter widths
// and a small helper for sizing FIFO pointers.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    // Config FSM: either nothing is waiting, or a shadow config waits for RX idle
    typedef enum logic {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_t;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int FIFO_DEPTH_DEF  = 4;
    localparam int PRESC_WIDTH_DEF = 6;
    localparam int CNT_WIDTH_DEF   = 8;

    // Prescale the RX core runs with until software writes a new config
    localparam int PRESCALE_RESET  = 8;

    // Index width of a power-of-two FIFO; the pointers carry one extra MSB
    // on top of this to tell full from empty
    function automatic int ptr_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_if
// Valid/ready stream carrying received bytes from the controller's buffer to
// the system side.
//   out_valid  buffer holds at least one byte
//   out_data   head byte of the buffer
//   out_ready  consumer accepts the head byte this cycle
// Modports: master = byte source (uart_rx_ctrl), slave = consumer.
// -----------------------------------------------------------------------------
interface uart_rx_ctrl_if
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/uart_rx_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_sync_fifo
// Small single-clock byte buffer between the RX core and the system side.
// Ports:
//   clk        system clock
//   syn_reset  synchronous active-high reset, clears pointers and storage
//   wr_req     byte offered for storage this cycle
//   wr_data    byte offered with wr_req
//   rd_req     consumer takes the head byte this cycle (ignored when empty)
//   empty      no byte stored
//   dropped    wr_req was refused because the buffer was full with no pop
//   head       head byte; while empty it shows the most recently removed byte
// -----------------------------------------------------------------------------
module uart_rx_sync_fifo
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  syn_reset,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    output logic                  empty,
    output logic                  dropped,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int AW = ptr_bits(FIFO_DEPTH);
    localparam logic [AW:0]   PTR_ONE = 1;
    localparam logic [AW-1:0] IDX_ONE = 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW-1:0]         wr_idx;
    logic [AW-1:0]         rd_idx;
    logic [AW-1:0]         last_idx;
    logic                  full;
    logic                  push_ok;
    logic                  pop_ok;

    assign wr_idx   = wr_ptr[AW-1:0];
    assign rd_idx   = rd_ptr[AW-1:0];
    assign last_idx = rd_idx - IDX_ONE;

    // Same index with differing wrap bits means the writer is a full lap ahead
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

    // A pop in the same cycle frees the slot, so a full buffer can still accept
    assign pop_ok  = rd_req && !empty;
    assign push_ok = wr_req && (!full || pop_ok);
    assign dropped = wr_req && !push_ok;

    // The slot just behind the read pointer is never written while empty,
    // so the output holds the last byte handed out (0 after reset)
    assign head = empty ? mem[last_idx] : mem[rd_idx];

    always_ff @(posedge clk) begin
        if (syn_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_idx] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Configures and sequences the UART RX core: holds the active prescale and
// parity settings, applies new settings and disables reception only between
// frames, buffers received bytes for the system side and keeps saturating
// parity/stop error counts.
// Ports:
//   clk, syn_reset            system clock, synchronous active-high reset
//   cfg_wr                    pulse: capture cfg_prescale/cfg_parity_* into shadow
//   cfg_prescale              requested prescale
//   cfg_parity_enable/_type   requested parity enable / type (0 even, 1 odd)
//   en_req                    requested RX enable level
//   rx_busy                   RX core is inside a frame
//   rx_data_valid, rx_p_data  pulse + byte for a good frame
//   rx_parity_error           pulse: parity error seen by the core
//   rx_stop_error             pulse: stop error seen by the core
//   cnt_clr                   clear both error counters and the overflow flag
//   rx_enable                 enable to the RX core
//   prescale, parity_enable, parity_type   active config to the RX core
//   cfg_pending               shadow config waiting for the core to go idle
//   cfg_applied               pulse: shadow config became active
//   overflow                  sticky: a byte was dropped on a full buffer
//   parity_err_cnt, stop_err_cnt          saturating error counts
//   out_if (master)           byte stream to the system side
// -----------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int PRESC_WIDTH = PRESC_WIDTH_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   syn_reset,
    input  logic                   cfg_wr,
    input  logic [PRESC_WIDTH-1:0] cfg_prescale,
    input  logic                   cfg_parity_enable,
    input  logic                   cfg_parity_type,
    input  logic                   en_req,
    input  logic                   rx_busy,
    input  logic                   rx_data_valid,
    input  logic [DATA_WIDTH-1:0]  rx_p_data,
    input  logic                   rx_parity_error,
    input  logic                   rx_stop_error,
    input  logic                   cnt_clr,
    output logic                   rx_enable,
    output logic [PRESC_WIDTH-1:0] prescale,
    output logic                   parity_enable,
    output logic                   parity_type,
    output logic                   cfg_pending,
    output logic                   cfg_applied,
    output logic                   overflow,
    output logic [CNT_WIDTH-1:0]   parity_err_cnt,
    output logic [CNT_WIDTH-1:0]   stop_err_cnt,
    uart_rx_ctrl_if.master         out_if
);

    localparam logic [PRESC_WIDTH-1:0] PRESC_RST = PRESC_WIDTH'(PRESCALE_RESET);
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = 1;

    cfg_state_t               cfg_state;
    logic [PRESC_WIDTH-1:0]   shadow_prescale;
    logic                     shadow_parity_enable;
    logic                     shadow_parity_type;
    logic                     fifo_empty;
    logic                     fifo_dropped;

    // Byte buffer; bytes are accepted regardless of rx_enable so that a frame
    // finishing just after a disable is not lost
    uart_rx_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .syn_reset (syn_reset),
        .wr_req    (rx_data_valid),
        .wr_data   (rx_p_data),
        .rd_req    (out_if.out_ready),
        .empty     (fifo_empty),
        .dropped   (fifo_dropped),
        .head      (out_if.out_data)
    );

    assign out_if.out_valid = !fifo_empty;

    // Config FSM and enable gating. A write always lands in the shadow; the
    // shadow is copied to the active outputs only at an edge where the core
    // is idle, so the core never sees its settings change inside a frame.
    // A write arriving on a commit edge is kept for a second commit.
    always_ff @(posedge clk) begin
        if (syn_reset) begin
            cfg_state            <= CFG_IDLE;
            shadow_prescale      <= PRESC_RST;
            shadow_parity_enable <= 1'b0;
            shadow_parity_type   <= 1'b0;
            prescale             <= PRESC_RST;
            parity_enable        <= 1'b0;
            parity_type          <= 1'b0;
            cfg_pending          <= 1'b0;
            cfg_applied          <= 1'b0;
            rx_enable            <= 1'b0;
        end else begin
            cfg_applied <= 1'b0;

            case (cfg_state)
                CFG_IDLE: begin
                    if (cfg_wr) begin
                        shadow_prescale      <= cfg_prescale;
                        shadow_parity_enable <= cfg_parity_enable;
                        shadow_parity_type   <= cfg_parity_type;
                        cfg_state            <= CFG_PEND;
                        cfg_pending          <= 1'b1;
                    end
                end
                CFG_PEND: begin
                    if (!rx_busy) begin
                        prescale      <= shadow_prescale;
                        parity_enable <= shadow_parity_enable;
                        parity_type   <= shadow_parity_type;
                        cfg_applied   <= 1'b1;
                    end
                    if (cfg_wr) begin
                        shadow_prescale      <= cfg_prescale;
                        shadow_parity_enable <= cfg_parity_enable;
                        shadow_parity_type   <= cfg_parity_type;
                    end else if (!rx_busy) begin
                        cfg_state   <= CFG_IDLE;
                        cfg_pending <= 1'b0;
                    end
                end
                default: begin
                    cfg_state   <= CFG_IDLE;
                    cfg_pending <= 1'b0;
                end
            endcase

            // Enabling is immediate; disabling waits for the frame to end
            if (en_req) begin
                rx_enable <= 1'b1;
            end else if (!rx_busy) begin
                rx_enable <= 1'b0;
            end
        end
    end

    // Error statistics and the dropped-byte flag. Clearing takes priority
    // over any event in the same cycle; counters stick at their maximum.
    always_ff @(posedge clk) begin
        if (syn_reset) begin
            parity_err_cnt <= '0;
            stop_err_cnt   <= '0;
            overflow       <= 1'b0;
        end else if (cnt_clr) begin
            parity_err_cnt <= '0;
            stop_err_cnt   <= '0;
            overflow       <= 1'b0;
        end else begin
            if (rx_parity_error && (parity_err_cnt != CNT_MAX)) begin
                parity_err_cnt <= parity_err_cnt + CNT_ONE;
            end
            if (rx_stop_error && (stop_err_cnt != CNT_MAX)) begin
                stop_err_cnt <= stop_err_cnt + CNT_ONE;
            end
            if (fifo_dropped) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Scenario tasks for uart_rx_ctrl plus a randomized run against a queue-based
// reference model of the byte buffer, counters and enable gating.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int PW    = 6;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          syn_reset;
    logic          cfg_wr;
    logic [PW-1:0] cfg_prescale;
    logic          cfg_parity_enable;
    logic          cfg_parity_type;
    logic          en_req;
    logic          rx_busy;
    logic          rx_data_valid;
    logic [DW-1:0] rx_p_data;
    logic          rx_parity_error;
    logic          rx_stop_error;
    logic          cnt_clr;
    logic          rx_enable;
    logic [PW-1:0] prescale;
    logic          parity_enable;
    logic          parity_type;
    logic          cfg_pending;
    logic          cfg_applied;
    logic          overflow;
    logic [CW-1:0] parity_err_cnt;
    logic [CW-1:0] stop_err_cnt;

    int checks   = 0;
    int failures = 0;

    uart_rx_ctrl_if #(.DATA_WIDTH(DW)) out_if ();

    uart_rx_ctrl #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .PRESC_WIDTH (PW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk               (clk),
        .syn_reset         (syn_reset),
        .cfg_wr            (cfg_wr),
        .cfg_prescale      (cfg_prescale),
        .cfg_parity_enable (cfg_parity_enable),
        .cfg_parity_type   (cfg_parity_type),
        .en_req            (en_req),
        .rx_busy           (rx_busy),
        .rx_data_valid     (rx_data_valid),
        .rx_p_data         (rx_p_data),
        .rx_parity_error   (rx_parity_error),
        .rx_stop_error     (rx_stop_error),
        .cnt_clr           (cnt_clr),
        .rx_enable         (rx_enable),
        .prescale          (prescale),
        .parity_enable     (parity_enable),
        .parity_type       (parity_type),
        .cfg_pending       (cfg_pending),
        .cfg_applied       (cfg_applied),
        .overflow          (overflow),
        .parity_err_cnt    (parity_err_cnt),
        .stop_err_cnt      (stop_err_cnt),
        .out_if            (out_if.master)
    );

    // Clock; inputs change and outputs are sampled on the falling edge
    always #5 clk = ~clk;

    // Hard stop in case something stalls the sequence
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        cfg_wr            = 1'b0;
        cfg_prescale      = '0;
        cfg_parity_enable = 1'b0;
        cfg_parity_type   = 1'b0;
        en_req            = 1'b0;
        rx_busy           = 1'b0;
        rx_data_valid     = 1'b0;
        rx_p_data         = '0;
        rx_parity_error   = 1'b0;
        rx_stop_error     = 1'b0;
        cnt_clr           = 1'b0;
        out_if.out_ready  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        syn_reset = 1'b1;
        next_cycle();
        next_cycle();
        syn_reset = 1'b0;
    endtask

    // Every output at its reset value
    task automatic test_reset();
        syn_reset = 1'b0;
        clear_inputs();
        next_cycle();
        do_reset();
        checks++; if (rx_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_enable got=%0b exp=0", rx_enable); end
        checks++; if (prescale !== 6'd8) begin failures++; $display("[TB] FAIL reset_prescale got=%0d exp=8", prescale); end
        checks++; if (parity_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_parity_enable got=%0b exp=0", parity_enable); end
        checks++; if (parity_type !== 1'b0) begin failures++; $display("[TB] FAIL reset_parity_type got=%0b exp=0", parity_type); end
        checks++; if (cfg_pending !== 1'b0) begin failures++; $display("[TB] FAIL reset_cfg_pending got=%0b exp=0", cfg_pending); end
        checks++; if (cfg_applied !== 1'b0) begin failures++; $display("[TB] FAIL reset_cfg_applied got=%0b exp=0", cfg_applied); end
        checks++; if (out_if.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_if.out_valid); end
        checks++; if (out_if.out_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_out_data got=%0h exp=0", out_if.out_data); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%0b exp=0", overflow); end
        checks++; if (parity_err_cnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_parity_cnt got=%0d exp=0", parity_err_cnt); end
        checks++; if (stop_err_cnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_stop_cnt got=%0d exp=0", stop_err_cnt); end
    endtask

    // Config write while the core is idle: active one edge after capture
    task automatic test_cfg_idle();
        do_reset();
        cfg_prescale      = 6'd16;
        cfg_parity_enable = 1'b1;
        cfg_parity_type   = 1'b1;
        cfg_wr            = 1'b1;
        next_cycle();
        cfg_wr = 1'b0;
        checks++; if (cfg_pending !== 1'b1) begin failures++; $display("[TB] FAIL idle_pending_set got=%0b exp=1", cfg_pending); end
        checks++; if (prescale !== 6'd8) begin failures++; $display("[TB] FAIL idle_prescale_early got=%0d exp=8", prescale); end
        next_cycle();
        checks++; if (prescale !== 6'd16) begin failures++; $display("[TB] FAIL idle_prescale got=%0d exp=16", prescale); end
        checks++; if (parity_enable !== 1'b1) begin failures++; $display("[TB] FAIL idle_parity_enable got=%0b exp=1", parity_enable); end
        checks++; if (parity_type !== 1'b1) begin failures++; $display("[TB] FAIL idle_parity_type got=%0b exp=1", parity_type); end
        checks++; if (cfg_applied !== 1'b1) begin failures++; $display("[TB] FAIL idle_applied got=%0b exp=1", cfg_applied); end
        checks++; if (cfg_pending !== 1'b0) begin failures++; $display("[TB] FAIL idle_pending_clr got=%0b exp=0", cfg_pending); end
        next_cycle();
        checks++; if (cfg_applied !== 1'b0) begin failures++; $display("[TB] FAIL idle_applied_pulse got=%0b exp=0", cfg_applied); end
    endtask

    // Writes while busy: last one wins, single commit on idle; then a write
    // coinciding with a commit edge
    task automatic test_cfg_busy();
        int applied_seen;
        applied_seen = 0;
        do_reset();
        rx_busy           = 1'b1;
        cfg_prescale      = 6'd32;
        cfg_parity_enable = 1'b1;
        cfg_parity_type   = 1'b1;
        cfg_wr            = 1'b1;
        next_cycle();
        cfg_prescale      = 6'd4;
        cfg_parity_enable = 1'b0;
        cfg_parity_type   = 1'b0;
        next_cycle();
        cfg_wr = 1'b0;
        repeat (4) begin
            checks++; if (prescale !== 6'd8) begin failures++; $display("[TB] FAIL busy_hold_prescale got=%0d exp=8", prescale); end
            checks++; if (cfg_pending !== 1'b1) begin failures++; $display("[TB] FAIL busy_hold_pending got=%0b exp=1", cfg_pending); end
            if (cfg_applied === 1'b1) applied_seen++;
            next_cycle();
        end
        rx_busy = 1'b0;
        next_cycle();
        if (cfg_applied === 1'b1) applied_seen++;
        checks++; if (prescale !== 6'd4) begin failures++; $display("[TB] FAIL busy_commit_prescale got=%0d exp=4", prescale); end
        checks++; if (parity_enable !== 1'b0) begin failures++; $display("[TB] FAIL busy_commit_parity_en got=%0b exp=0", parity_enable); end
        checks++; if (cfg_pending !== 1'b0) begin failures++; $display("[TB] FAIL busy_commit_pending got=%0b exp=0", cfg_pending); end
        next_cycle();
        if (cfg_applied === 1'b1) applied_seen++;
        checks++; if (applied_seen !== 1) begin failures++; $display("[TB] FAIL busy_applied_count got=%0d exp=1", applied_seen); end

        cfg_prescale = 6'd10;
        cfg_wr       = 1'b1;
        next_cycle();
        cfg_prescale = 6'd12;
        next_cycle();
        cfg_wr = 1'b0;
        checks++; if (prescale !== 6'd10) begin failures++; $display("[TB] FAIL overlap_first_prescale got=%0d exp=10", prescale); end
        checks++; if (cfg_applied !== 1'b1) begin failures++; $display("[TB] FAIL overlap_first_applied got=%0b exp=1", cfg_applied); end
        checks++; if (cfg_pending !== 1'b1) begin failures++; $display("[TB] FAIL overlap_still_pending got=%0b exp=1", cfg_pending); end
        next_cycle();
        checks++; if (prescale !== 6'd12) begin failures++; $display("[TB] FAIL overlap_second_prescale got=%0d exp=12", prescale); end
        checks++; if (cfg_pending !== 1'b0) begin failures++; $display("[TB] FAIL overlap_done_pending got=%0b exp=0", cfg_pending); end
    endtask

    // Fill with the consumer stalled, drop one byte, drain in order
    task automatic test_fifo_overflow();
        logic [7:0] bytes [4] = '{8'hA5, 8'h3C, 8'h55, 8'hFF};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rx_data_valid = 1'b1;
            rx_p_data     = bytes[i];
            next_cycle();
        end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_before_drop got=%0b exp=0", overflow); end
        rx_p_data = 8'h11;
        next_cycle();
        rx_data_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_after_drop got=%0b exp=1", overflow); end
        out_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_if.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL ovf_drain_valid[%0d] got=%0b exp=1", i, out_if.out_valid); end
            checks++; if (out_if.out_data !== bytes[i]) begin failures++; $display("[TB] FAIL ovf_drain_data[%0d] got=%0h exp=%0h", i, out_if.out_data, bytes[i]); end
            next_cycle();
        end
        out_if.out_ready = 1'b0;
        checks++; if (out_if.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_empty_valid got=%0b exp=0", out_if.out_valid); end
        checks++; if (out_if.out_data !== 8'hFF) begin failures++; $display("[TB] FAIL ovf_hold_data got=%0h exp=ff", out_if.out_data); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky got=%0b exp=1", overflow); end
        cnt_clr = 1'b1;
        next_cycle();
        cnt_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_cleared got=%0b exp=0", overflow); end
    endtask

    // Full buffer with push and pop in the same cycle
    task automatic test_fifo_full_push_pop();
        logic [7:0] bytes [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bytes[i]      = 8'($urandom);
            rx_data_valid = 1'b1;
            rx_p_data     = bytes[i];
            next_cycle();
        end
        rx_p_data        = 8'h77;
        out_if.out_ready = 1'b1;
        checks++; if (out_if.out_data !== bytes[0]) begin failures++; $display("[TB] FAIL fpp_head0 got=%0h exp=%0h", out_if.out_data, bytes[0]); end
        next_cycle();
        rx_data_valid = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL fpp_no_overflow got=%0b exp=0", overflow); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (out_if.out_data !== bytes[i]) begin failures++; $display("[TB] FAIL fpp_data[%0d] got=%0h exp=%0h", i, out_if.out_data, bytes[i]); end
            next_cycle();
        end
        checks++; if (out_if.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL fpp_last_valid got=%0b exp=1", out_if.out_valid); end
        checks++; if (out_if.out_data !== 8'h77) begin failures++; $display("[TB] FAIL fpp_last_data got=%0h exp=77", out_if.out_data); end
        next_cycle();
        out_if.out_ready = 1'b0;
        checks++; if (out_if.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL fpp_empty got=%0b exp=0", out_if.out_valid); end
    endtask

    // Saturation at 255 and clear beating a simultaneous increment
    task automatic test_counters();
        do_reset();
        rx_stop_error = 1'b1;
        repeat (3) next_cycle();
        rx_stop_error = 1'b0;
        checks++; if (stop_err_cnt !== 8'd3) begin failures++; $display("[TB] FAIL cnt_stop3 got=%0d exp=3", stop_err_cnt); end
        rx_parity_error = 1'b1;
        repeat (254) next_cycle();
        checks++; if (parity_err_cnt !== 8'd254) begin failures++; $display("[TB] FAIL cnt_parity254 got=%0d exp=254", parity_err_cnt); end
        next_cycle();
        checks++; if (parity_err_cnt !== 8'd255) begin failures++; $display("[TB] FAIL cnt_parity255 got=%0d exp=255", parity_err_cnt); end
        repeat (45) next_cycle();
        rx_parity_error = 1'b0;
        checks++; if (parity_err_cnt !== 8'd255) begin failures++; $display("[TB] FAIL cnt_parity_sat got=%0d exp=255", parity_err_cnt); end
        cnt_clr       = 1'b1;
        rx_stop_error = 1'b1;
        next_cycle();
        cnt_clr       = 1'b0;
        rx_stop_error = 1'b0;
        checks++; if (parity_err_cnt !== 8'd0) begin failures++; $display("[TB] FAIL cnt_clr_parity got=%0d exp=0", parity_err_cnt); end
        checks++; if (stop_err_cnt !== 8'd0) begin failures++; $display("[TB] FAIL cnt_clr_stop got=%0d exp=0", stop_err_cnt); end
    endtask

    // Disable deferred to frame end; reset while a config is pending
    task automatic test_enable_and_reset();
        do_reset();
        en_req = 1'b1;
        next_cycle();
        checks++; if (rx_enable !== 1'b1) begin failures++; $display("[TB] FAIL en_rise got=%0b exp=1", rx_enable); end
        rx_busy = 1'b1;
        en_req  = 1'b0;
        repeat (3) begin
            next_cycle();
            checks++; if (rx_enable !== 1'b1) begin failures++; $display("[TB] FAIL en_hold_busy got=%0b exp=1", rx_enable); end
        end
        rx_busy = 1'b0;
        next_cycle();
        checks++; if (rx_enable !== 1'b0) begin failures++; $display("[TB] FAIL en_fall got=%0b exp=0", rx_enable); end

        rx_busy         = 1'b1;
        en_req          = 1'b1;
        cfg_prescale    = 6'd20;
        cfg_wr          = 1'b1;
        rx_data_valid   = 1'b1;
        rx_p_data       = 8'h5A;
        rx_parity_error = 1'b1;
        next_cycle();
        cfg_wr          = 1'b0;
        rx_data_valid   = 1'b0;
        rx_parity_error = 1'b0;
        checks++; if (cfg_pending !== 1'b1) begin failures++; $display("[TB] FAIL rst_pending_before got=%0b exp=1", cfg_pending); end
        syn_reset = 1'b1;
        next_cycle();
        syn_reset = 1'b0;
        en_req    = 1'b0;
        checks++; if (cfg_pending !== 1'b0) begin failures++; $display("[TB] FAIL rst_pending_after got=%0b exp=0", cfg_pending); end
        checks++; if (rx_enable !== 1'b0) begin failures++; $display("[TB] FAIL rst_rx_enable got=%0b exp=0", rx_enable); end
        checks++; if (out_if.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid got=%0b exp=0", out_if.out_valid); end
        checks++; if (parity_err_cnt !== 8'd0) begin failures++; $display("[TB] FAIL rst_parity_cnt got=%0d exp=0", parity_err_cnt); end
        rx_busy = 1'b0;
        repeat (2) begin
            next_cycle();
            checks++; if (cfg_applied !== 1'b0) begin failures++; $display("[TB] FAIL rst_no_apply got=%0b exp=0", cfg_applied); end
        end
        checks++; if (prescale !== 6'd8) begin failures++; $display("[TB] FAIL rst_prescale got=%0d exp=8", prescale); end
    endtask

    // Randomized traffic against a behavioural model: byte queue bounded by
    // DEPTH, counters clamped at 255, sticky drop flag, deferred disable
    task automatic test_random();
        logic [7:0] mq [$];
        int         m_par;
        int         m_stop;
        bit         m_ovf;
        bit         m_en;
        int         ready_pct;
        bit         v, r, pe, se, clr, busy, en;
        logic [7:0] d;
        bit         pop;

        do_reset();
        m_par = 0; m_stop = 0; m_ovf = 1'b0; m_en = 1'b0; ready_pct = 30;
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++; if (out_if.out_valid !== (mq.size() != 0)) begin failures++; $display("[TB] FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, out_if.out_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                checks++; if (out_if.out_data !== mq[0]) begin failures++; $display("[TB] FAIL rnd_data cyc=%0d got=%0h exp=%0h", cyc, out_if.out_data, mq[0]); end
            end
            checks++; if (overflow !== m_ovf) begin failures++; $display("[TB] FAIL rnd_overflow cyc=%0d got=%0b exp=%0b", cyc, overflow, m_ovf); end
            checks++; if (parity_err_cnt !== 8'(m_par)) begin failures++; $display("[TB] FAIL rnd_parity_cnt cyc=%0d got=%0d exp=%0d", cyc, parity_err_cnt, m_par); end
            checks++; if (stop_err_cnt !== 8'(m_stop)) begin failures++; $display("[TB] FAIL rnd_stop_cnt cyc=%0d got=%0d exp=%0d", cyc, stop_err_cnt, m_stop); end
            checks++; if (rx_enable !== m_en) begin failures++; $display("[TB] FAIL rnd_rx_enable cyc=%0d got=%0b exp=%0b", cyc, rx_enable, m_en); end

            if ((cyc % 50) == 0) ready_pct = (ready_pct == 30) ? 80 : 30;
            v    = ($urandom_range(0, 99) < 55);
            d    = 8'($urandom);
            r    = ($urandom_range(0, 99) < ready_pct);
            pe   = ($urandom_range(0, 3) == 0);
            se   = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 31) == 0);
            busy = ($urandom_range(0, 1) == 1);
            en   = ($urandom_range(0, 2) == 0);

            rx_data_valid    = v;
            rx_p_data        = d;
            out_if.out_ready = r;
            rx_parity_error  = pe;
            rx_stop_error    = se;
            cnt_clr          = clr;
            rx_busy          = busy;
            en_req           = en;

            pop = (mq.size() != 0) && r;
            if (v && !((mq.size() < DEPTH) || pop)) m_ovf = 1'b1;
            if (pop) void'(mq.pop_front());
            if (v && (mq.size() < DEPTH)) mq.push_back(d);
            if (clr) begin
                m_par = 0; m_stop = 0; m_ovf = 1'b0;
            end else begin
                if (pe && m_par < 255) m_par++;
                if (se && m_stop < 255) m_stop++;
            end
            if (en) m_en = 1'b1;
            else if (!busy) m_en = 1'b0;
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        $display("[TB] uart_rx_ctrl bench start");
        test_reset();
        test_cfg_idle();
        test_cfg_busy();
        test_fifo_overflow();
        test_fifo_full_push_pop();
        test_counters();
        test_enable_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
